// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states
// and condition-code bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_SHL1  = 3'd2,
    OP_SHR1  = 3'd3,
    OP_PASSA = 3'd4,
    OP_PASSB = 3'd5,
    OP_MAX   = 3'd6,
    OP_MUL   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// The start edge already folds in bit 0, so WIDTH edges in total are used.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic [2*WIDTH-1:0] part;

  assign part = mplier_q[0] ? mcand_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
      mplier_q <= b_i >> 1;
      cnt_q    <= LAST;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        acc_q    <= acc_q + part;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o    = run_q && (cnt_q == '0);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops retire at the accept edge, MUL runs
// on the iterative multiplier; results held until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       cc,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [3:0]         cc_q, cc_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   alu_r;
  logic [3:0]         alu_cc;
  logic [WIDTH-1:0]   mul_r;
  logic [3:0]         mul_cc;
  logic               accept;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_r  = '0;
    alu_cc = '0;
    unique case (op_e'(op))
      OP_ADD: begin
        alu_r        = sum[WIDTH-1:0];
        alu_cc[CC_C] = sum[WIDTH];
        alu_cc[CC_V] = (a[WIDTH-1] == b[WIDTH-1]) &&
                       (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r        = dif[WIDTH-1:0];
        alu_cc[CC_C] = (a < b);
        alu_cc[CC_V] = (a[WIDTH-1] != b[WIDTH-1]) &&
                       (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL1: begin
        alu_r        = {a[WIDTH-2:0], 1'b0};
        alu_cc[CC_C] = a[WIDTH-1];
      end
      OP_SHR1: begin
        alu_r        = {1'b0, a[WIDTH-1:1]};
        alu_cc[CC_C] = a[0];
      end
      OP_PASSA: alu_r = a;
      OP_PASSB: alu_r = b;
      OP_MAX:   alu_r = (a >= b) ? a : b;
      OP_MUL:   alu_r = '0;
    endcase
    alu_cc[CC_N] = alu_r[WIDTH-1];
    alu_cc[CC_Z] = (alu_r == '0);
  end

  always_comb begin
    mul_r         = mul_prod[WIDTH-1:0];
    mul_cc        = '0;
    mul_cc[CC_N]  = mul_r[WIDTH-1];
    mul_cc[CC_Z]  = (mul_r == '0);
    mul_cc[CC_C]  = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cc_d      = cc_q;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_e'(op) == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            r_d     = alu_r;
            cc_d    = alu_cc;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          r_d     = mul_r;
          cc_d    = mul_cc;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cc_q    <= cc_d;
    end
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (a),
    .b_i      (b),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign r         = r_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table plus
// backpressure and reset-abort sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [3:0]   cc;
  logic         busy;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r        (r),
    .cc       (cc),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] cc;
    int         lat;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, output logic [7:0] rr,
                        output logic [3:0] cr, output int lat,
                        output int bn);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    op = 3'($urandom);
    lat = 1;
    bn = 0;
    while (!out_valid && lat < 50) begin
      if (busy) bn++;
      step();
      lat++;
    end
    rr = r;
    cr = cc;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rr;
    logic [3:0] cr;
    int lat;
    int bn;

    vt[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1};
    vt[1]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b1010, 1};
    vt[2]  = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b0100, 1};
    vt[3]  = '{3'd7, 8'h10, 8'h11, 8'h10, 4'b0010, 9};
    vt[4]  = '{3'd7, 8'h0F, 8'h03, 8'h2D, 4'b0000, 9};
    vt[5]  = '{3'd2, 8'h81, 8'h00, 8'h02, 4'b0010, 1};
    vt[6]  = '{3'd3, 8'h81, 8'h00, 8'h40, 4'b0010, 1};
    vt[7]  = '{3'd6, 8'h80, 8'h7F, 8'h80, 4'b1000, 1};
    vt[8]  = '{3'd4, 8'h00, 8'h55, 8'h00, 4'b0100, 1};
    vt[9]  = '{3'd5, 8'h12, 8'hC3, 8'hC3, 4'b1000, 1};
    vt[10] = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b0110, 1};
    vt[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1};
    vt[12] = '{3'd6, 8'h05, 8'h05, 8'h05, 4'b0000, 1};
    vt[13] = '{3'd6, 8'h03, 8'hF0, 8'hF0, 4'b1000, 1};
    vt[14] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0010, 9};
    vt[15] = '{3'd7, 8'h00, 8'h37, 8'h00, 4'b0100, 9};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    step();
    step();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst r", 32'(r), 0);
    chk("rst cc", 32'(cc), 0);
    rst = 1'b0;
    step();
    chk("rst in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 16; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, rr, cr, lat, bn);
      chk($sformatf("v%0d r", i), 32'(rr), 32'(vt[i].r));
      chk($sformatf("v%0d cc", i), 32'(cr), 32'(vt[i].cc));
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d busy", i), 32'(bn), 32'(vt[i].lat - 1));
      chk($sformatf("v%0d retire", i), 32'(out_valid), 0);
    end

    // backpressure: result held, in_ready low, new requests ignored
    op = 3'd0;
    a = 8'h7F;
    b = 8'h01;
    in_valid = 1'b1;
    step();
    op = 3'd1;
    a = 8'h33;
    b = 8'h11;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d out_valid", k), 32'(out_valid), 1);
      chk($sformatf("bp%0d in_ready", k), 32'(in_ready), 0);
      chk($sformatf("bp%0d r", k), 32'(r), 32'h80);
      chk($sformatf("bp%0d cc", k), 32'(cc), 32'h9);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp retire out_valid", 32'(out_valid), 0);
    chk("bp no accept busy", 32'(busy), 0);
    chk("bp in_ready", 32'(in_ready), 1);

    // reset during MUL aborts it
    op = 3'd7;
    a = 8'h10;
    b = 8'h11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("mid-mul busy", 32'(busy), 1);
    rst = 1'b1;
    #2;
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort r", 32'(r), 0);
    chk("abort cc", 32'(cc), 0);
    step();
    rst = 1'b0;
    step();
    chk("abort stays idle", 32'(out_valid), 0);
    run_op(3'd0, 8'h01, 8'h02, rr, cr, lat, bn);
    chk("post-rst r", 32'(rr), 32'h03);
    chk("post-rst cc", 32'(cr), 0);
    chk("post-rst lat", 32'(lat), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
